// File: rtl/icache_fetch_port_if.sv
// Fetch-side and memory-side signals of icache_fetch_port, bundled with
// cache-side (slave) and environment-side (master) views. Stats outputs exist only with ICACHE_STATS_EN.
interface icache_fetch_port_if;
   logic        instr_read_in;
   logic [63:0] instr_address_in;
   logic        invalidate_in;
   logic [63:0] instr_read_value_out;
   logic        stall_out;
   logic        mem_req_out;
   logic [63:0] mem_addr_out;
   logic        mem_ready_in;
   logic        mem_rvalid_in;
   logic [63:0] mem_rdata_in;
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_count_out;
   logic [31:0] miss_count_out;
`endif

   modport slave (
      input  instr_read_in, instr_address_in, invalidate_in,
      input  mem_ready_in, mem_rvalid_in, mem_rdata_in,
`ifdef ICACHE_STATS_EN
      output hit_count_out, miss_count_out,
`endif
      output instr_read_value_out, stall_out, mem_req_out, mem_addr_out
   );

   modport master (
      output instr_read_in, instr_address_in, invalidate_in,
      output mem_ready_in, mem_rvalid_in, mem_rdata_in,
`ifdef ICACHE_STATS_EN
      input  hit_count_out, miss_count_out,
`endif
      input  instr_read_value_out, stall_out, mem_req_out, mem_addr_out
   );
endinterface

// File: rtl/icache_fetch_port.sv
// Direct-mapped instruction cache, one 64-bit word per line, single outstanding refill.
// Optional hit/miss counters are compiled in with ICACHE_STATS_EN.
module icache_fetch_port #(
   parameter  int LINES = 16,
   localparam int IDX_W = $clog2(LINES)
) (
   input logic              clk,
   input logic              rst_n,
   icache_fetch_port_if.slave bus
);
   localparam int TAG_W = 61 - IDX_W;

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [IDX_W-1:0] idx;
   } line_t;

   state_t           state;
   logic [LINES-1:0] valid;
   logic [TAG_W-1:0] tag_mem  [LINES];
   logic [63:0]      data_mem [LINES];
   logic             drop;
   logic             mem_req_q;
   logic [63:0]      mem_addr_q;

   line_t cur, fill;
   logic  hit, miss_start, fill_done;

   assign cur  = bus.instr_address_in[63:3];
   assign fill = mem_addr_q[63:3];

   assign hit        = (state == IDLE) && valid[cur.idx] && (tag_mem[cur.idx] == cur.tag);
   assign miss_start = (state == IDLE) && bus.instr_read_in && !hit;
   assign fill_done  = (state == WAIT) && bus.mem_rvalid_in;

   assign bus.stall_out            = bus.instr_read_in && ((state != IDLE) || !hit);
   assign bus.instr_read_value_out = data_mem[cur.idx];
   assign bus.mem_req_out          = mem_req_q;
   assign bus.mem_addr_out         = mem_addr_q;

   logic unused_addr_lsb;
   assign unused_addr_lsb = ^bus.instr_address_in[2:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         valid      <= '0;
         drop       <= 1'b0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
      end else begin
         case (state)
            IDLE: if (miss_start) begin
               mem_addr_q <= {bus.instr_address_in[63:3], 3'b000};
               mem_req_q  <= 1'b1;
               state      <= REQ;
            end
            REQ: if (bus.mem_ready_in) begin
               mem_req_q <= 1'b0;
               state     <= WAIT;
            end
            WAIT: if (bus.mem_rvalid_in) state <= IDLE;
            default: begin
               mem_req_q <= 1'b0;
               state     <= IDLE;
            end
         endcase

         // Invalidate always wins over a coincident fill; a fill whose request
         // straddled an invalidate lands its data but stays invalid.
         if (bus.invalidate_in)
            valid <= '0;
         else if (fill_done && !drop)
            valid[fill.idx] <= 1'b1;

         if (fill_done)
            drop <= 1'b0;
         else if (bus.invalidate_in && (state != IDLE))
            drop <= 1'b1;
      end
   end

   // Data and tag arrays carry no reset; the valid bits guard them.
   always_ff @(posedge clk) begin
      if (fill_done) begin
         data_mem[fill.idx] <= bus.mem_rdata_in;
         tag_mem[fill.idx]  <= fill.tag;
      end
   end

`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt, miss_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if (bus.instr_read_in && hit) hit_cnt  <= hit_cnt + 32'd1;
         if (miss_start)               miss_cnt <= miss_cnt + 32'd1;
      end
   end

   assign bus.hit_count_out  = hit_cnt;
   assign bus.miss_count_out = miss_cnt;
`endif
endmodule
